// File: rtl/gf2m_mul_serial.sv
// Digit-serial GF(2^WIDTH) multiplier, reduced by x^WIDTH + POLY.
// Operands arrive on a valid/ready handshake, and the product leaves on a second one.
module gf2m_mul_serial #(
    parameter int                 WIDTH = 8,
    parameter logic [WIDTH-1:0]   POLY  = 8'h1B,
    parameter int                 DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1) begin : g_bad_size
            $error("gf2m_mul_serial: WIDTH must be >= 2 and DIGIT >= 1");
        end else if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("gf2m_mul_serial: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_q, b_q, acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_step, b_step;
    logic               accept, last;

    // Multiply by x, folding the overflow term back in through the field polynomial.
    function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
    endfunction

    // NOTE: blocking assignments here build a combinational chain of DIGIT
    // Horner steps; each iteration sees the previous iteration's result.
    always_comb begin
        acc_step = acc_q;
        b_step   = b_q;
        for (int i = 0; i < DIGIT; i++) begin
            acc_step = xtime(acc_step) ^ (b_step[WIDTH-1] ? a_q : '0);
            b_step   = b_step << 1;
        end
    end

    assign accept = in_valid & in_ready;
    assign last   = (cnt_q == CNT_W'(N - 1));

    // NOTE: every register, including the operand/accumulator datapath, is cleared
    // asynchronously so an abandoned operation leaves no residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next takes a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (last)   state_next = DONE;
            DONE: if (out_ready) state_next = in_valid ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) | ((state == DONE) & out_ready);
        busy     = (state == BUSY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state == BUSY) begin
            acc_q <= acc_step;
            b_q   <= b_step;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // q keeps the last product after the handshake; only out_valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q         <= '0;
            out_valid <= 1'b0;
        end else if ((state == BUSY) && last) begin
            q         <= acc_step;
            out_valid <= 1'b1;
        end else if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gf2m_mul_serial.sv
// Directed bench for gf2m_mul_serial: four instances covering GF(2^8) and GF(2^4)
// with several digit sizes, handshake latency, back-to-back, backpressure and reset.
module tb_gf2m_mul_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_valid_v, out_ready_v;
    logic [3:0] in_ready_v, out_valid_v, busy_v;
    logic [7:0] a_s [4];
    logic [7:0] b_s [4];
    logic [7:0] q0, q1;
    logic [3:0] q2, q3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gf2m_mul_serial #(.WIDTH(8), .POLY(8'h1B), .DIGIT(1)) u_w8_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .q(q0), .busy(busy_v[0]));

    gf2m_mul_serial #(.WIDTH(8), .POLY(8'h1B), .DIGIT(4)) u_w8_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .q(q1), .busy(busy_v[1]));

    gf2m_mul_serial #(.WIDTH(4), .POLY(4'h3), .DIGIT(1)) u_w4_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_s[2][3:0]), .b(b_s[2][3:0]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .q(q2), .busy(busy_v[2]));

    gf2m_mul_serial #(.WIDTH(4), .POLY(4'h3), .DIGIT(2)) u_w4_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .a(a_s[3][3:0]), .b(b_s[3][3:0]), .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
        .q(q3), .busy(busy_v[3]));

    function automatic logic [7:0] q_of(input int s);
        case (s)
            0:       return q0;
            1:       return q1;
            2:       return {4'h0, q2};
            default: return {4'h0, q3};
        endcase
    endfunction

    // LSB-first shift-and-add in GF(2^4) with x^4 + x + 1.
    function automatic logic [3:0] ref_mul4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] r = 4'h0;
        logic [3:0] t = x;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) r = r ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // One full transaction: accept, measure latency, compare q, then drain.
    task automatic do_op(input int s, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ex, input int n, input string tag);
        int wait_cyc = 0;
        int lat      = 0;
        @(posedge clk); #1;
        while (!in_ready_v[s] && wait_cyc < 40) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        if (!in_ready_v[s]) check({tag, "_in_ready_timeout"}, 0, 1);
        a_s[s] = av;
        b_s[s] = bv;
        in_valid_v[s] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[s] = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid_v[s] && lat < 64);
        check({tag, "_latency"}, lat, n);
        check({tag, "_q"}, q_of(s), ex);
        out_ready_v[s] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[s] = 1'b0;
    endtask

    initial begin
        logic [7:0] pa [3];
        logic [7:0] pb [3];
        logic [7:0] pe [3];
        logic [7:0] q_hold;
        int         idx_in, got, last_cyc, cyc, bad;
        logic       acc_now, ov_now;

        rst         = 1'b1;
        in_valid_v  = '0;
        out_ready_v = '0;
        for (int i = 0; i < 4; i++) begin
            a_s[i] = '0;
            b_s[i] = '0;
        end
        #1;
        check("rst_in_ready", in_ready_v, 4'hF);
        check("rst_out_valid", out_valid_v, 4'h0);
        check("rst_busy", busy_v, 4'h0);
        check("rst_q", {q0, q1, q2, q3}, 24'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // out_ready with nothing pending must not change anything
        out_ready_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        out_ready_v[0] = 1'b0;
        check("idle_out_ready_ov", out_valid_v[0], 1'b0);
        check("idle_out_ready_busy", busy_v[0], 1'b0);

        do_op(0, 8'h57, 8'h83, 8'hC1, 8, "w8d1_57x83");
        do_op(1, 8'h53, 8'hCA, 8'h01, 2, "w8d4_53xCA");
        do_op(1, 8'h57, 8'h13, 8'hFE, 2, "w8d4_57x13");
        do_op(1, 8'h00, 8'hFF, 8'h00, 2, "w8d4_00xFF");
        do_op(2, 8'h02, 8'h08, 8'h03, 4, "w4d1_2x8");
        do_op(2, 8'h0F, 8'h0F, 8'h0A, 4, "w4d1_FxF");
        do_op(3, 8'h02, 8'h08, 8'h03, 2, "w4d2_2x8");
        do_op(3, 8'h0F, 8'h0F, 8'h0A, 2, "w4d2_FxF");

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
                do_op(2, 8'(x), 8'(y), {4'h0, ref_mul4(4'(x), 4'(y))}, 4, "w4d1_exh");
                do_op(3, 8'(x), 8'(y), {4'h0, ref_mul4(4'(x), 4'(y))}, 2, "w4d2_exh");
            end

        // Back-to-back: three queued pairs, results N+1 = 9 cycles apart
        pa[0] = 8'h57; pb[0] = 8'h83; pe[0] = 8'hC1;
        pa[1] = 8'h53; pb[1] = 8'hCA; pe[1] = 8'h01;
        pa[2] = 8'h57; pb[2] = 8'h13; pe[2] = 8'hFE;
        @(posedge clk); #1;
        idx_in = 0; got = 0; last_cyc = -1;
        a_s[0] = pa[0]; b_s[0] = pb[0];
        in_valid_v[0]  = 1'b1;
        out_ready_v[0] = 1'b1;
        for (cyc = 0; cyc < 100 && got < 3; cyc++) begin
            @(negedge clk);
            acc_now = in_valid_v[0] & in_ready_v[0];
            ov_now  = out_valid_v[0];
            if (ov_now) begin
                check("b2b_q", q0, pe[got]);
                if (got > 0) check("b2b_spacing", cyc - last_cyc, 9);
                last_cyc = cyc;
                got++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                idx_in++;
                if (idx_in < 3) begin
                    a_s[0] = pa[idx_in];
                    b_s[0] = pb[idx_in];
                end else begin
                    in_valid_v[0] = 1'b0;
                end
            end
        end
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b0;
        check("b2b_count", got, 3);
        @(posedge clk); #1;
        check("b2b_idle", in_ready_v[0], 1'b1);

        // Backpressure: product held, new operands refused while out_ready=0
        @(posedge clk); #1;
        a_s[0] = 8'h57; b_s[0] = 8'h13;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        a_s[0] = 8'hFF; b_s[0] = 8'hFF;
        cyc = 0;
        while (!out_valid_v[0] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        q_hold = q0;
        check("bp_first_q", q_hold, 8'hFE);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid_v[0] !== 1'b1 || q0 !== 8'hFE || in_ready_v[0] !== 1'b0) bad++;
        end
        check("bp_stable_cycles_bad", bad, 0);
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
        check("bp_release_ov", out_valid_v[0], 1'b0);
        check("bp_release_busy", busy_v[0], 1'b0);
        check("bp_release_q_kept", q0, 8'hFE);
        @(posedge clk); #1;
        check("bp_single_transfer", out_valid_v[0], 1'b0);

        // Reset in the third BUSY cycle abandons the operation
        a_s[0] = 8'h57; b_s[0] = 8'h83;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("rst_mid_busy_before", busy_v[0], 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_ov", out_valid_v[0], 1'b0);
        check("rst_mid_busy", busy_v[0], 1'b0);
        check("rst_mid_in_ready", in_ready_v[0], 1'b1);
        check("rst_mid_q", q0, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) bad++;
        end
        check("rst_mid_no_pulse_bad", bad, 0);
        do_op(0, 8'h57, 8'h83, 8'hC1, 8, "post_rst_57x83");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
